sr_lsu: RTL and testbench

//  Load/store unit on the data side of the core. Receives the decoded memory

---
 rtl/sr_lsu.sv | 210 +++++++++++++++++++++
 tb/tb_sr_lsu.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_lsu.sv
// Load/store unit: one sized data-memory access per core request over a req/ack bus.
// Optional misaligned-access trap enabled by defining SR_LSU_MISALIGN_TRAP_EN.
module sr_lsu #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsuReq,
    input  logic        dmWe,
    input  logic        dmSign,
    input  logic [2:0]  dmRMode,
    input  logic [31:0] lsuAddr,
    input  logic [31:0] lsuWData,
    output logic        lsuStall,
    output logic        lsuDone,
    output logic        lsuErr,
    output logic [31:0] lsuRData,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [3:0]  memBe,
    output logic [31:0] memWData,
    input  logic        memAck,
    input  logic [31:0] memRData
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

    // Anything that is not a clean one-hot byte/half code is a word access.
    function automatic logic [1:0] size_decode(input logic [2:0] mode);
        logic [1:0] sz;
        case (mode)
            3'b100:  sz = SZ_BYTE;
            3'b010:  sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic [3:0] be_decode(input logic [1:0] sz, input logic [1:0] a);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << a;
            SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] wdata_replicate(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] res;
        case (sz)
            SZ_BYTE: res = {4{wd[7:0]}};
            SZ_HALF: res = {2{wd[15:0]}};
            default: res = wd;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [1:0] a,
                                                 input logic [1:0] sz, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (sz)
            SZ_BYTE: res = {{24{sgn & b[7]}}, b};
            SZ_HALF: res = {{16{sgn & h[15]}}, h};
            default: res = rd;
        endcase
        return res;
    endfunction

    logic [1:0]  state_r;
    logic [1:0]  state_nx_s;
    logic [15:0] cnt_r;
    logic [1:0]  size_s;
    logic        misalign_s;
    logic        accept_s;
    logic [29:0] addr_r;
    logic [1:0]  lane_r;
    logic [1:0]  size_r;
    logic        sign_r;
    logic        we_r;
    logic [3:0]  be_r;
    logic [31:0] wdata_r;
    logic        mem_req_r;
    logic        mem_we_r;
    logic        done_r;
    logic        err_r;
    logic [31:0] rdata_r;

    assign size_s   = size_decode(dmRMode);
    assign accept_s = (state_r == ST_IDLE) && lsuReq;

`ifdef SR_LSU_MISALIGN_TRAP_EN
    assign misalign_s = ((size_s == SZ_HALF) && lsuAddr[0]) ||
                        ((size_s == SZ_WORD) && (lsuAddr[1:0] != 2'b00));
`else
    assign misalign_s = 1'b0;
`endif

    // Next-state decode; an ack in the final timeout cycle still completes normally.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (lsuReq) state_nx_s = misalign_s ? ST_ERR : ST_REQ;
                else        state_nx_s = ST_IDLE;
            end
            ST_REQ: begin
                if (memAck)                 state_nx_s = ST_RESP;
                else if (cnt_r == TMO_LAST) state_nx_s = ST_ERR;
                else                        state_nx_s = ST_REQ;
            end
            ST_RESP: state_nx_s = ST_IDLE;
            ST_ERR:  state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register and wait-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
        end else begin
            state_r <= state_nx_s;
            if (accept_s)                            cnt_r <= 16'd0;
            else if ((state_r == ST_REQ) && !memAck) cnt_r <= cnt_r + 16'd1;
            else                                     cnt_r <= cnt_r;
        end
    end

    // Capture of the request so the bus sees stable controls throughout REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r  <= 30'd0;
            lane_r  <= 2'd0;
            size_r  <= SZ_WORD;
            sign_r  <= 1'b0;
            we_r    <= 1'b0;
            be_r    <= 4'd0;
            wdata_r <= 32'd0;
        end else if (accept_s) begin
            addr_r  <= lsuAddr[31:2];
            lane_r  <= lsuAddr[1:0];
            size_r  <= size_s;
            sign_r  <= dmSign;
            we_r    <= dmWe;
            be_r    <= be_decode(size_s, lsuAddr[1:0]);
            wdata_r <= wdata_replicate(size_s, lsuWData);
        end else begin
            addr_r  <= addr_r;
            lane_r  <= lane_r;
            size_r  <= size_r;
            sign_r  <= sign_r;
            we_r    <= we_r;
            be_r    <= be_r;
            wdata_r <= wdata_r;
        end
    end

    // Registered handshake and result outputs, decoded from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            rdata_r   <= 32'd0;
        end else begin
            mem_req_r <= (state_nx_s == ST_REQ);
            if (accept_s)                  mem_we_r <= dmWe & ~misalign_s;
            else if (state_nx_s != ST_REQ) mem_we_r <= 1'b0;
            else                           mem_we_r <= mem_we_r;
            done_r    <= (state_nx_s == ST_RESP) || (state_nx_s == ST_ERR);
            err_r     <= (state_nx_s == ST_ERR);
            if ((state_r == ST_REQ) && memAck && !we_r)
                rdata_r <= load_extract(memRData, lane_r, size_r, sign_r);
            else
                rdata_r <= 32'd0;
        end
    end

    assign memReq   = mem_req_r;
    assign memWe    = mem_we_r;
    assign memAddr  = {addr_r, 2'b00};
    assign memBe    = be_r;
    assign memWData = wdata_r;
    assign lsuDone  = done_r;
    assign lsuErr   = err_r;
    assign lsuRData = rdata_r;
    assign lsuStall = lsuReq & ~done_r;

endmodule

// File: tb/tb_sr_lsu.sv
// Self-checking bench for sr_lsu: directed cases plus randomized accesses against a reference model.
module tb_sr_lsu;
    localparam int TMO = 4;
`ifdef SR_LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsuReq = 1'b0;
    logic        dmWe = 1'b0;
    logic        dmSign = 1'b0;
    logic [2:0]  dmRMode = 3'b001;
    logic [31:0] lsuAddr = 32'd0;
    logic [31:0] lsuWData = 32'd0;
    logic        lsuStall, lsuDone, lsuErr, memReq, memWe;
    logic [31:0] lsuRData, memAddr, memWData;
    logic [3:0]  memBe;
    logic        memAck = 1'b0;
    logic [31:0] memRData = 32'd0;

    always #5 clk = ~clk;

    sr_lsu #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .lsuReq(lsuReq), .dmWe(dmWe), .dmSign(dmSign),
        .dmRMode(dmRMode), .lsuAddr(lsuAddr), .lsuWData(lsuWData), .lsuStall(lsuStall),
        .lsuDone(lsuDone), .lsuErr(lsuErr), .lsuRData(lsuRData), .memReq(memReq),
        .memWe(memWe), .memAddr(memAddr), .memBe(memBe), .memWData(memWData),
        .memAck(memAck), .memRData(memRData)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0]  obs_be;
    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic        obs_we, obs_err;
    int          obs_req, obs_done, obs_stall;

    // Reference model: sizes 1/2/4 bytes, arithmetic lane selection.
    function automatic int m_bytes(input logic [2:0] mode);
        if (mode == 3'b100) return 1;
        if (mode == 3'b010) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] mode);
        int n, v;
        n = m_bytes(mode);
        if (n == 1)      v = 1 << (a % 4);
        else if (n == 2) v = 3 << (2 * ((a / 2) % 2));
        else             v = 15;
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [2:0] mode);
        int n;
        n = m_bytes(mode);
        if (n == 1) return (wd % 256) * 32'h0101_0101;
        if (n == 2) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [2:0] mode, input logic sgn);
        int n, off;
        longint v, span;
        n = m_bytes(mode);
        if (n == 4) return rd;
        off  = (n == 1) ? int'(a % 4) : 2 * int'((a / 2) % 2);
        span = longint'(1) << (8 * n);
        v    = (longint'(rd) >> (8 * off)) % span;
        if (sgn && (v >= span / 2)) v = v - span;
        return v[31:0];
    endfunction

    function automatic bit m_misaligned(input logic [31:0] a, input logic [2:0] mode);
        int n;
        n = m_bytes(mode);
        return (n == 2 && (a % 2) != 0) || (n == 4 && (a % 4) != 0);
    endfunction

    // Drives one access and records what the bus and core sides saw; delay<0 means never ack.
    task automatic do_access(input logic [31:0] a, input logic we, input logic sgn,
                             input logic [2:0] mode, input logic [31:0] wd,
                             input logic [31:0] rd, input int delay);
        obs_be = 4'd0; obs_addr = 32'd0; obs_wdata = 32'd0; obs_we = 1'b0;
        obs_req = 0; obs_done = -1; obs_stall = 0; obs_err = 1'b0; obs_rdata = 32'd0;
        @(negedge clk);
        lsuReq = 1'b1; dmWe = we; dmSign = sgn; dmRMode = mode;
        lsuAddr = a; lsuWData = wd; memAck = 1'b0;
        #1;
        if (lsuStall) obs_stall++;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (memReq) begin
                if (obs_req == 0) begin
                    obs_be = memBe; obs_addr = memAddr; obs_wdata = memWData; obs_we = memWe;
                end
                obs_req++;
            end
            if (lsuStall) obs_stall++;
            if (lsuDone) begin
                obs_done = k; obs_err = lsuErr; obs_rdata = lsuRData;
                break;
            end
            if (memReq && delay >= 0 && obs_req == delay + 1) begin
                memAck = 1'b1; memRData = rd;
            end else begin
                memAck = 1'b0; memRData = $urandom;
            end
        end
        lsuReq = 1'b0; memAck = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++; if ({memReq, memWe, lsuDone, lsuErr, lsuStall} !== 5'b0) begin n_bad++; $display("FAIL reset_ctrl got=%b want=00000", {memReq, memWe, lsuDone, lsuErr, lsuStall}); end
        n_cmp++; if ({memAddr, memWData, lsuRData, memBe} !== 100'd0) begin n_bad++; $display("FAIL reset_data addr=%h wd=%h rd=%h be=%b want all zero", memAddr, memWData, lsuRData, memBe); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_lb_signed();
        do_access(32'h0000_1003, 1'b0, 1'b1, 3'b100, $urandom, 32'h80AA_BBCC, 0);
        n_cmp++; if (obs_be !== 4'b1000) begin n_bad++; $display("FAIL lb_be got=%b want=1000", obs_be); end
        n_cmp++; if (obs_addr !== 32'h0000_1000) begin n_bad++; $display("FAIL lb_addr got=%h want=00001000", obs_addr); end
        n_cmp++; if (obs_rdata !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_rdata got=%h want=ffffff80", obs_rdata); end
        n_cmp++; if (obs_done !== 2 || obs_err !== 1'b0) begin n_bad++; $display("FAIL lb_done cycle=%0d err=%b want 2/0", obs_done, obs_err); end
    endtask

    task automatic test_lhu_wait();
        do_access(32'h0000_1002, 1'b0, 1'b0, 3'b010, $urandom, 32'h8001_1234, 3);
        n_cmp++; if (obs_be !== 4'b1100) begin n_bad++; $display("FAIL lhu_be got=%b want=1100", obs_be); end
        n_cmp++; if (obs_rdata !== 32'h0000_8001) begin n_bad++; $display("FAIL lhu_rdata got=%h want=00008001", obs_rdata); end
        n_cmp++; if (obs_stall !== 5) begin n_bad++; $display("FAIL lhu_stall got=%0d want=5", obs_stall); end
        n_cmp++; if (obs_done !== 5) begin n_bad++; $display("FAIL lhu_done got=%0d want=5", obs_done); end
    endtask

    task automatic test_sb();
        do_access(32'h0000_2001, 1'b1, 1'b0, 3'b100, 32'h1234_56A5, $urandom, 0);
        n_cmp++; if (obs_we !== 1'b1 || obs_be !== 4'b0010) begin n_bad++; $display("FAIL sb_we_be got=%b/%b want=1/0010", obs_we, obs_be); end
        n_cmp++; if (obs_wdata !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL sb_wdata got=%h want=a5a5a5a5", obs_wdata); end
        n_cmp++; if (obs_addr !== 32'h0000_2000) begin n_bad++; $display("FAIL sb_addr got=%h want=00002000", obs_addr); end
        n_cmp++; if (obs_rdata !== 32'd0 || obs_done !== 2) begin n_bad++; $display("FAIL sb_resp rdata=%h done=%0d want 0/2", obs_rdata, obs_done); end
    endtask

    task automatic test_timeout();
        do_access(32'h0000_0040, 1'b0, 1'b0, 3'b001, 32'd0, 32'd0, -1);
        n_cmp++; if (obs_req !== TMO) begin n_bad++; $display("FAIL tmo_req_cycles got=%0d want=%0d", obs_req, TMO); end
        n_cmp++; if (obs_done !== TMO + 1 || obs_err !== 1'b1) begin n_bad++; $display("FAIL tmo_done cycle=%0d err=%b want %0d/1", obs_done, obs_err, TMO + 1); end
        n_cmp++; if (obs_rdata !== 32'd0) begin n_bad++; $display("FAIL tmo_rdata got=%h want=0", obs_rdata); end
        @(negedge clk);
        n_cmp++; if (memReq !== 1'b0 || lsuDone !== 1'b0) begin n_bad++; $display("FAIL tmo_idle memReq=%b done=%b want 0/0", memReq, lsuDone); end
    endtask

    task automatic test_misalign();
        do_access(32'h0000_3002, 1'b0, 1'b0, 3'b001, 32'd0, 32'h0BAD_F00D, 0);
        n_cmp++; if (obs_req !== (TRAP ? 0 : 1)) begin n_bad++; $display("FAIL mis_req got=%0d want=%0d", obs_req, TRAP ? 0 : 1); end
        n_cmp++; if (obs_err !== TRAP || obs_done !== (TRAP ? 1 : 2)) begin n_bad++; $display("FAIL mis_done err=%b cycle=%0d want %b/%0d", obs_err, obs_done, TRAP, TRAP ? 1 : 2); end
        n_cmp++; if (obs_addr !== (TRAP ? 32'd0 : 32'h0000_3000) || obs_be !== (TRAP ? 4'd0 : 4'hF)) begin n_bad++; $display("FAIL mis_bus addr=%h be=%b", obs_addr, obs_be); end
        n_cmp++; if (obs_rdata !== (TRAP ? 32'd0 : 32'h0BAD_F00D)) begin n_bad++; $display("FAIL mis_rdata got=%h", obs_rdata); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        @(negedge clk);
        lsuReq = 1'b1; dmWe = 1'b0; dmRMode = 3'b001; lsuAddr = 32'h0000_4000; memAck = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (memReq !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre memReq=%b want=1", memReq); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (memReq !== 1'b0 || lsuDone !== 1'b0) begin n_bad++; $display("FAIL rstmid_async memReq=%b done=%b want 0/0", memReq, lsuDone); end
        lsuReq = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        rd = $urandom;
        do_access(32'h0000_4004, 1'b0, 1'b0, 3'b001, 32'd0, rd, 1);
        n_cmp++; if (obs_done !== 3 || obs_err !== 1'b0 || obs_rdata !== rd) begin n_bad++; $display("FAIL rstmid_after done=%0d err=%b rdata=%h want 3/0/%h", obs_done, obs_err, obs_rdata, rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rda, rdb;
        rda = $urandom; rdb = $urandom;
        @(negedge clk);
        memAck = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (lsuDone !== 1'b0 || memReq !== 1'b0) begin n_bad++; $display("FAIL stray_ack done=%b memReq=%b want 0/0", lsuDone, memReq); end
        memAck = 1'b0;
        lsuReq = 1'b1; dmWe = 1'b0; dmRMode = 3'b001; lsuAddr = 32'h0000_5000;
        @(negedge clk);
        memAck = 1'b1; memRData = rda;
        @(negedge clk);
        n_cmp++; if (lsuDone !== 1'b1 || lsuRData !== rda) begin n_bad++; $display("FAIL b2b_first done=%b rdata=%h want 1/%h", lsuDone, lsuRData, rda); end
        memAck = 1'b0; lsuAddr = 32'h0000_5010;
        @(negedge clk);
        n_cmp++; if (memReq !== 1'b0 || lsuDone !== 1'b0 || lsuStall !== 1'b1) begin n_bad++; $display("FAIL b2b_gap memReq=%b done=%b stall=%b want 0/0/1", memReq, lsuDone, lsuStall); end
        @(negedge clk);
        n_cmp++; if (memReq !== 1'b1 || memAddr !== 32'h0000_5010) begin n_bad++; $display("FAIL b2b_second memReq=%b addr=%h want 1/00005010", memReq, memAddr); end
        memAck = 1'b1; memRData = rdb;
        @(negedge clk);
        n_cmp++; if (lsuDone !== 1'b1 || lsuRData !== rdb) begin n_bad++; $display("FAIL b2b_second_done done=%b rdata=%h want 1/%h", lsuDone, lsuRData, rdb); end
        memAck = 1'b0; lsuReq = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0]  modes [6] = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b110, 3'b111};
        logic [31:0] a, wd, rd, e_rdata;
        logic [2:0]  mode;
        logic        we, sgn;
        int          delay, e_req, e_done;
        bit          mis, e_err;
        for (int i = 0; i < 80; i++) begin
            a = $urandom; wd = $urandom; rd = $urandom;
            mode = modes[$urandom_range(0, 5)];
            we = 1'($urandom_range(0, 1)); sgn = 1'($urandom_range(0, 1));
            delay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 2));
            mis     = TRAP && m_misaligned(a, mode);
            e_req   = mis ? 0 : ((delay < 0) ? TMO : delay + 1);
            e_done  = mis ? 1 : ((delay < 0) ? TMO + 1 : delay + 2);
            e_err   = mis || (delay < 0);
            e_rdata = (e_err || we) ? 32'd0 : m_load(rd, a, mode, sgn);
            do_access(a, we, sgn, mode, wd, rd, delay);
            n_cmp++; if (obs_req !== e_req || obs_done !== e_done || obs_err !== e_err) begin n_bad++; $display("FAIL rand%0d_timing req=%0d done=%0d err=%b want %0d/%0d/%b", i, obs_req, obs_done, obs_err, e_req, e_done, e_err); end
            n_cmp++; if (obs_rdata !== e_rdata) begin n_bad++; $display("FAIL rand%0d_rdata a=%h mode=%b sgn=%b got=%h want=%h", i, a, mode, sgn, obs_rdata, e_rdata); end
            if (!mis) begin
                n_cmp++; if (obs_be !== m_be(a, mode) || obs_addr !== {a[31:2], 2'b00}) begin n_bad++; $display("FAIL rand%0d_bus be=%b addr=%h want %b/%h", i, obs_be, obs_addr, m_be(a, mode), {a[31:2], 2'b00}); end
                n_cmp++; if (obs_we !== we || obs_wdata !== m_wdata(wd, mode)) begin n_bad++; $display("FAIL rand%0d_store we=%b wd=%h want %b/%h", i, obs_we, obs_wdata, we, m_wdata(wd, mode)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lb_signed();
        test_lhu_wait();
        test_sb();
        test_timeout();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
